reveal_ctrl: RTL and testbench

REVEAL_CTRL -- requirements
Module: reveal_ctrl

---
 rtl/reveal_ctrl.sv | 164 ++++++++++++++++
 tb/tb_reveal_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reveal_ctrl.sv
// ============================================================================
// reveal_ctrl : click-driven cell reveal controller with optional flood fill
//   Optional feature: define REVEAL_CASCADE_EN for the SCAN flood fill.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module reveal_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [255:0] map_flat,
  input  logic         game_over,
  input  logic         click_valid,
  input  logic [2:0]   click_row,
  input  logic [2:0]   click_col,
  output logic         click_ready,
  output logic         busy,
  output logic         done,
  output logic [63:0]  clicked_flat,
  output logic [5:0]   num_clicked
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [63:0] clicked_q, clicked_d;
  logic [5:0]  num_q, num_d;
  logic [63:0] new_bits;
  logic [3:0]  new_cnt;
  logic [6:0]  num_sum;

  function automatic logic [3:0] cell_val(input logic [255:0] m, input logic [5:0] i);
    return m[{i, 2'b00} +: 4];
  endfunction

`ifdef REVEAL_CASCADE_EN
  logic [5:0]  k_q, k_d;
  logic        changed_q, changed_d;
  logic [63:0] scan_bits;

  // Unrevealed, non-mine, in-board neighbours of scan cell k (only if k is a revealed zero)
  always_comb begin : scan_neighbours
    int nr;
    int nc;
    logic [5:0] ni;
    scan_bits = '0;
    nr = 0;
    nc = 0;
    ni = '0;
    if (clicked_q[k_q] && (cell_val(map_flat, k_q) == 4'd0)) begin
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          nr = int'(k_q[5:3]) + dr;
          nc = int'(k_q[2:0]) + dc;
          if (!(dr == 0 && dc == 0) && nr >= 0 && nr <= 7 && nc >= 0 && nc <= 7) begin
            ni = 6'(nr * 8 + nc);
            if (cell_val(map_flat, ni) < 4'd9 && !clicked_q[ni]) begin
              scan_bits[ni] = 1'b1;
            end
          end
        end
      end
    end
  end
`endif

  always_comb begin : next_state
    state_d  = state_q;
    idx_d    = idx_q;
    new_bits = '0;
`ifdef REVEAL_CASCADE_EN
    k_d       = k_q;
    changed_d = changed_q;
`endif
    case (state_q)
      IDLE: begin
        if (click_valid && !game_over) begin
          idx_d   = {click_row, click_col};
          state_d = OPEN;
        end
      end
      OPEN: begin
        state_d = DONE;
        if (!clicked_q[idx_q]) begin
          new_bits[idx_q] = 1'b1;
`ifdef REVEAL_CASCADE_EN
          k_d       = '0;
          changed_d = 1'b0;
          if (cell_val(map_flat, idx_q) == 4'd0) begin
            state_d = SCAN;
          end
`endif
        end
      end
`ifdef REVEAL_CASCADE_EN
      SCAN: begin
        new_bits = scan_bits;
        // A reveal at k==63 still needs another pass so its neighbours get scanned
        if (|scan_bits) begin
          changed_d = 1'b1;
        end
        if (k_q == 6'd63) begin
          if (changed_d) begin
            changed_d = 1'b0;
            k_d       = '0;
          end else begin
            state_d = DONE;
          end
        end else begin
          k_d = k_q + 6'd1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    new_cnt = '0;
    for (int i = 0; i < 64; i++) begin
      new_cnt = new_cnt + {3'b000, new_bits[i]};
    end
    clicked_d = clicked_q | new_bits;
    num_sum   = {1'b0, num_q} + {3'b000, new_cnt};
    num_d     = (num_sum > 7'd63) ? 6'd63 : num_sum[5:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      clicked_q <= '0;
      num_q     <= '0;
`ifdef REVEAL_CASCADE_EN
      k_q       <= '0;
      changed_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clicked_q <= clicked_d;
      num_q     <= num_d;
`ifdef REVEAL_CASCADE_EN
      k_q       <= k_d;
      changed_q <= changed_d;
`endif
    end
  end

  assign click_ready  = (state_q == IDLE) && !game_over;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign clicked_flat = clicked_q;
  assign num_clicked  = num_q;

endmodule

`default_nettype wire

// File: tb/tb_reveal_ctrl.sv
// ============================================================================
// tb_reveal_ctrl : scoreboard bench for reveal_ctrl with a board-level model
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reveal_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] map_flat = '0;
  logic         game_over = 1'b0;
  logic         click_valid = 1'b0;
  logic [2:0]   click_row = '0;
  logic [2:0]   click_col = '0;
  logic         click_ready;
  logic         busy;
  logic         done;
  logic [63:0]  clicked_flat;
  logic [5:0]   num_clicked;

  reveal_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .map_flat    (map_flat),
    .game_over   (game_over),
    .click_valid (click_valid),
    .click_row   (click_row),
    .click_col   (click_col),
    .click_ready (click_ready),
    .busy        (busy),
    .done        (done),
    .clicked_flat(clicked_flat),
    .num_clicked (num_clicked)
  );

  always #5 clk = ~clk;

`ifdef REVEAL_CASCADE_EN
  localparam int ABORT_WAIT = 10;
`else
  localparam int ABORT_WAIT = 0;
`endif

  typedef struct packed {
    logic [63:0] rev;
    logic [5:0]  num;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [63:0] m_rev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int val(input int i);
    return int'(map_flat[4*i +: 4]);
  endfunction

  function automatic logic [5:0] model_num();
    int n;
    n = $countones(m_rev);
    return (n > 63) ? 6'd63 : 6'(n);
  endfunction

  // Board model: reveal target; a zero target floods until no revealed zero has a hidden safe neighbour
  task automatic model_click(input int idx);
    bit grew;
    if (m_rev[idx]) return;
    m_rev[idx] = 1'b1;
`ifdef REVEAL_CASCADE_EN
    if (val(idx) == 0) begin
      do begin
        grew = 1'b0;
        for (int c = 0; c < 64; c++) begin
          if (m_rev[c] && val(c) == 0) begin
            for (int dr = -1; dr <= 1; dr++) begin
              for (int dc = -1; dc <= 1; dc++) begin
                int rr, cc, n;
                rr = c / 8 + dr;
                cc = c % 8 + dc;
                if (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
                  n = rr * 8 + cc;
                  if (!m_rev[n] && val(n) < 9) begin
                    m_rev[n] = 1'b1;
                    grew = 1'b1;
                  end
                end
              end
            end
          end
        end
      end while (grew);
    end
`endif
  endtask

  // Monitor: every done pulse retires one expected result
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending click");
        end else begin
          e = sb.pop_front();
          chk("sb_clicked_flat", clicked_flat, e.rev);
          chk("sb_num_clicked", 64'(num_clicked), 64'(e.num));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_async_clicked", clicked_flat, 64'd0);
    chk("rst_async_num", 64'(num_clicked), 64'd0);
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_done", 64'(done), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_fall_ready", 64'(click_ready), 64'(!game_over));
    chk("rst_fall_busy", 64'(busy), 64'd0);
    sb.delete();
    m_rev = '0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout: got busy=1 expected idle within %0d cycles", bound);
    end
  endtask

  task automatic issue_click(input int r, input int c);
    int n;
    n = 0;
    while (!click_ready && n < 100) begin
      tick();
      n++;
    end
    if (!click_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got click_ready=0 expected 1");
    end
    click_row   = 3'(r);
    click_col   = 3'(c);
    click_valid = 1'b1;
    model_click(r * 8 + c);
    sb.push_back('{rev: m_rev, num: model_num()});
    tick();
    click_valid = 1'b0;
  endtask

  initial begin
    int d0, gap, cyc;
    logic [63:0] snap;

    // Mid-run reset aborts processing with no done pulse
    map_flat = '0;
    do_reset();
    d0 = done_cnt;
    issue_click(0, 0);
    repeat (ABORT_WAIT) tick();
    chk("abort_busy_before", 64'(busy), 64'd1);
    do_reset();
    repeat (4) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_clicked", clicked_flat, 64'd0);

    // Numbered cell: exact two-cycle timing, no cascade
    for (int i = 0; i < 64; i++) map_flat[4*i +: 4] = 4'd1;
    map_flat[3:0] = 4'd9;
    do_reset();
    d0 = done_cnt;
    issue_click(3, 3);
    chk("num_e0_busy", 64'(busy), 64'd1);
    chk("num_e0_done", 64'(done), 64'd0);
    chk("num_e0_clicked", clicked_flat, 64'd0);
    tick();
    chk("num_e1_clicked", clicked_flat, 64'h0000_0000_0800_0000);
    chk("num_e1_done", 64'(done), 64'd1);
    tick();
    chk("num_e2_ready", 64'(click_ready), 64'd1);
    chk("num_e2_busy", 64'(busy), 64'd0);
    chk("num_count", 64'(num_clicked), 64'd1);
    chk("num_one_done", 64'(done_cnt - d0), 64'd1);

    // Re-click of a revealed cell
    d0 = done_cnt;
    issue_click(3, 3);
    wait_idle(100);
    tick();
    chk("reclick_clicked", clicked_flat, 64'h0000_0000_0800_0000);
    chk("reclick_num", 64'(num_clicked), 64'd1);
    chk("reclick_done", 64'(done_cnt - d0), 64'd1);

    // Full cascade from a corner
    map_flat = '0;
    do_reset();
    d0 = done_cnt;
    issue_click(0, 0);
    gap = 0;
    cyc = 0;
    while (!done && cyc < 6000) begin
      if (!busy) gap++;
      tick();
      cyc++;
    end
    wait_idle(10);
    tick();
    chk("full_busy_gap", 64'(gap), 64'd0);
    chk("full_one_done", 64'(done_cnt - d0), 64'd1);
`ifdef REVEAL_CASCADE_EN
    chk("full_clicked", clicked_flat, {64{1'b1}});
    chk("full_num_sat", 64'(num_clicked), 64'd63);
`else
    chk("full_clicked", clicked_flat, 64'd1);
    chk("full_num", 64'(num_clicked), 64'd1);
`endif

    // Mine click, then game_over blocks clicks
    for (int i = 0; i < 64; i++) map_flat[4*i +: 4] = 4'd1;
    map_flat[4*9 +: 4] = 4'd9;
    do_reset();
    issue_click(1, 1);
    wait_idle(100);
    chk("mine_clicked", clicked_flat, 64'd1 << 9);
    chk("mine_num", 64'(num_clicked), 64'd1);
    game_over = 1'b1;
    #1;
    chk("over_ready", 64'(click_ready), 64'd0);
    click_row   = 3'd2;
    click_col   = 3'd2;
    click_valid = 1'b1;
    gap = 0;
    repeat (3) begin
      tick();
      if (busy) gap++;
    end
    click_valid = 1'b0;
    chk("over_ignored_busy", 64'(gap), 64'd0);
    chk("over_ignored_clicked", clicked_flat, 64'd1 << 9);
    game_over = 1'b0;

    // Edge column mines; clicks during busy are ignored
    map_flat = '0;
    map_flat[4*7 +: 4]  = 4'd9;
    map_flat[4*15 +: 4] = 4'd9;
    do_reset();
    d0 = done_cnt;
    issue_click(0, 0);
    cyc = 0;
    click_row = 3'd0;
    click_col = 3'd7;
    while (busy && cyc < 6000) begin
      click_valid = ~click_valid;
      tick();
      cyc++;
    end
    click_valid = 1'b0;
    wait_idle(10);
    repeat (3) tick();
    chk("edge_one_done", 64'(done_cnt - d0), 64'd1);
    chk("edge_mines_hidden", clicked_flat & 64'h0000_0000_0000_8080, 64'd0);
`ifdef REVEAL_CASCADE_EN
    chk("edge_cols_0_6", clicked_flat & 64'h7F7F_7F7F_7F7F_7F7F, 64'h7F7F_7F7F_7F7F_7F7F);
    chk("edge_num", 64'(num_clicked), 64'd62);
`else
    chk("edge_clicked", clicked_flat, 64'd1);
`endif

    // Randomized boards and clicks against the model
    for (int round = 0; round < 5; round++) begin
      for (int i = 0; i < 64; i++) begin
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 2)      map_flat[4*i +: 4] = 4'(9 + $urandom_range(0, 6));
        else if (r < 9) map_flat[4*i +: 4] = 4'd0;
        else            map_flat[4*i +: 4] = 4'($urandom_range(1, 8));
      end
      do_reset();
      for (int j = 0; j < 10; j++) begin
        issue_click(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
        wait_idle(6000);
      end
      tick();
      snap = m_rev;
      chk("rand_final_clicked", clicked_flat, snap);
    end

    tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
